// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with one-cycle latency, flush and synchronous reset.
// Define PIPE_STAGE_SKID_EN to add a skid entry so in_ready no longer depends on out_ready.
module pipe_stage_reg #(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        level
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] main_q, main_nxt;
  logic              valid_q;
  logic [1:0]        level_q;
  logic              in_xfer, out_xfer;

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] skid_q, skid_nxt;

  // Registered ready: only the FULL state blocks upstream, out_ready never reaches in_ready.
  assign in_ready = (state != FULL) && !flush && !rst;
`else
  assign in_ready = (!valid_q || out_ready) && !flush && !rst;
`endif

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = valid_q && out_ready;
  assign out_valid = valid_q;
  assign out_data  = main_q;
  assign level     = level_q;

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_nxt  = skid_q;
`endif
    if (rst || flush) begin
      state_nxt = EMPTY;
      main_nxt  = RST_VAL;
`ifdef PIPE_STAGE_SKID_EN
      skid_nxt  = RST_VAL;
`endif
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            state_nxt = MAIN;
            main_nxt  = in_data;
          end
        end
        MAIN: begin
          if (in_xfer && out_xfer) begin
            main_nxt = in_data;
          end else if (out_xfer) begin
            state_nxt = EMPTY;
            main_nxt  = RST_VAL;
          end
`ifdef PIPE_STAGE_SKID_EN
          else if (in_xfer) begin
            state_nxt = FULL;
            skid_nxt  = in_data;
          end
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        FULL: begin
          if (out_xfer) begin
            state_nxt = MAIN;
            main_nxt  = skid_q;
            skid_nxt  = RST_VAL;
          end
        end
`endif
        default: begin
          state_nxt = EMPTY;
          main_nxt  = RST_VAL;
        end
      endcase
    end
  end

  // Valid and level are registered copies of the next state so they leave the block flop-direct.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      main_q  <= RST_VAL;
      valid_q <= 1'b0;
      level_q <= 2'd0;
    end else begin
      state   <= state_nxt;
      main_q  <= main_nxt;
      valid_q <= (state_nxt != EMPTY);
      level_q <= (state_nxt == FULL) ? 2'd2 : ((state_nxt == MAIN) ? 2'd1 : 2'd0);
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_q <= RST_VAL;
    end else begin
      skid_q <= skid_nxt;
    end
  end
`endif

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of the payload bus carried between stages.
REQ-002 Parameter RST_VAL, default 0, payload value driven whenever out_valid is 0 (bubble value).
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge only.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  synchronous kill of all held entries (exception/redirect).
REQ-006 in_valid  input  1  upstream presents a payload.
REQ-007 in_ready  output  1  stage accepts the payload this cycle.
REQ-008 in_data  input  DATA_W  upstream payload.
REQ-009 out_valid  output  1  stage presents a payload downstream.
REQ-010 out_ready  input  1  downstream accepts the payload this cycle.
REQ-011 out_data  output  DATA_W  payload presented downstream.
REQ-012 level  output  2  number of entries held (0, 1 or 2), registered.

Function
REQ-013 Input transfer SHALL occur on a rising edge with in_valid && in_ready; output transfer SHALL occur on a rising edge with out_valid && out_ready.
REQ-014 Payloads SHALL leave in acceptance order, with none lost or duplicated.
REQ-015 Latency SHALL be exactly 1 cycle: a payload accepted at edge N is on out_data with out_valid=1 after edge N, provided the stage was empty or drained at edge N.
REQ-016 Entries SHALL be a main register (drives out_data) plus, when configured, a skid register.
REQ-017 States SHALL be EMPTY (level 0), MAIN (level 1) and FULL (level 2; FULL exists only with skid).
REQ-018 EMPTY: on input transfer, go to MAIN.
REQ-019 MAIN: input without output, go to FULL (payload into skid) or, without skid, impossible by construction; output without input, go to EMPTY; both, stay MAIN with the new payload in main.
REQ-020 FULL: on output transfer, the skid entry moves to main and the state goes to MAIN; in_ready=0 in FULL.
REQ-021 When out_valid=0, out_data SHALL equal RST_VAL; on a transition to EMPTY, main SHALL be loaded with RST_VAL.
REQ-022 out_valid SHALL be a direct register output; out_data SHALL be a direct register output.
REQ-023 Flush SHALL take priority over all transfers: after the edge with flush=1, state is EMPTY, level=0, out_valid=0, out_data=RST_VAL.
REQ-024 in_ready SHALL be 0 in any cycle where flush=1, so no input transfer occurs.
REQ-025 Output transfers in a flush cycle SHALL still be counted as taken by downstream; the stage does not re-present them.
REQ-026 out_data and the skid payload SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-027 rst=1 SHALL have the same effect as flush and SHALL override flush: state EMPTY, level=0, out_valid=0, out_data=RST_VAL, skid=RST_VAL.
REQ-028 in_ready SHALL be 0 while rst=1; reset asserted mid-transfer SHALL discard every held entry.

Configuration
REQ-029 Macro PIPE_STAGE_SKID_EN defined: the skid register and FULL state exist, and in_ready = !FULL (registered, no combinational path from out_ready).
REQ-030 Macro PIPE_STAGE_SKID_EN undefined: single entry, level never exceeds 1, and in_ready = !out_valid || out_ready (combinational through-path), with full throughput preserved.

Verification
REQ-031 Stream 0x11,0x22,0x33 with out_ready=1 at all times -> outputs 0x11,0x22,0x33 on consecutive cycles, each 1 cycle after acceptance, level=1 throughout.
REQ-032 Skid on: accept 0xA1, then 0xA2 with out_ready=0 -> level=2 and in_ready=0; raise out_ready -> 0xA1 then 0xA2 out in order, level goes 2 then 1 then 0.
REQ-033 Hold: out_valid=1 with out_data=0xBEEF and out_ready=0 for 5 cycles -> out_data stays 0xBEEF and no input transfer occurs when FULL or unskidded.
REQ-034 Flush at level=2 with in_valid=1 and in_data=0x55 -> next cycle out_valid=0, out_data=RST_VAL, level=0, and 0x55 never appears.
REQ-035 rst and flush both high with RST_VAL=0xDEAD -> out_data=0xDEAD and level=0; after rst is released, the first accepted 0x01 appears 1 cycle later.
REQ-036 Skid off: random in_valid/out_ready for 1000 cycles against a reference FIFO model -> order matches, level<=1, and in_ready equals !out_valid||out_ready every cycle.
